// File: rtl/cpu_mc_if.sv
// rtl/cpu_mc_if.sv - fetch, load, halt and status bus between cpu_mc and its surroundings
interface cpu_mc_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 16
);
  logic [AW-1:0]      pc;
  logic               ins_req;
  logic [15:0]        ins;
  logic               ins_valid;
  logic               load_signal;
  logic [WIDTH-1:0]   load_data;
  logic               sys_signal;
  logic               sys_ack;
  logic [3*WIDTH-1:0] sysregs;
  logic [2:0]         flags;

  modport master (
    output pc, ins_req, sys_signal, sysregs, flags,
    input  ins, ins_valid, load_signal, load_data, sys_ack
  );

  modport slave (
    input  pc, ins_req, sys_signal, sysregs, flags,
    output ins, ins_valid, load_signal, load_data, sys_ack
  );
endinterface

// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multi-cycle 4/4/4/4 cpu with fetch handshake, flags and acknowledged SYS halt
module cpu_mc #(
  parameter int WIDTH = 16,
  parameter int AW    = 16
) (
  input  logic      clk,
  input  logic      clear,
  cpu_mc_if.master  bus
);
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             run_q, run_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic [2:0]       flags_q, flags_d;
  logic [WIDTH-1:0] regs_q [1:14];
  logic [WIDTH-1:0] regs_d [1:14];

  logic [3:0]       op, d_idx, s1_idx, s2_idx;
  logic [WIDTH-1:0] d_val, s1_val, s2_val, result;
  logic             carry, wr_en, flag_en, jump, is_call;
  logic [AW-1:0]    pc_inc, target;

  assign op     = ir_q[15:12];
  assign d_idx  = ir_q[11:8];
  assign s1_idx = ir_q[7:4];
  assign s2_idx = ir_q[3:0];
  assign pc_inc = pc_q + AW'(1);

  // run_q holds off the first fetch until one clock after clear is released
  assign bus.ins_req    = (state_q == S_FETCH) && run_q;
  assign bus.sys_signal = (state_q == S_HALT);
  assign bus.pc         = pc_q;
  assign bus.flags      = flags_q;
  assign bus.sysregs    = {regs_q[3], regs_q[2], regs_q[1]};

  // register-file reads: r0 is zero, r15 mirrors the pc
  always_comb begin
    d_val  = '0;
    s1_val = '0;
    s2_val = '0;
    if (d_idx == 4'd15)  d_val  = WIDTH'(pc_q);
    if (s1_idx == 4'd15) s1_val = WIDTH'(pc_q);
    if (s2_idx == 4'd15) s2_val = WIDTH'(pc_q);
    for (int i = 1; i <= 14; i++) begin
      if (d_idx == 4'(i))  d_val  = regs_q[i];
      if (s1_idx == 4'(i)) s1_val = regs_q[i];
      if (s2_idx == 4'(i)) s2_val = regs_q[i];
    end
  end

  // decode and ALU for the instruction held in the IR
  always_comb begin
    result  = '0;
    carry   = 1'b0;
    wr_en   = 1'b0;
    flag_en = 1'b0;
    jump    = 1'b0;
    is_call = 1'b0;
    target  = s1_val[AW-1:0];
    case (op)
      4'h1: begin {carry, result} = {1'b0, s1_val} + {1'b0, s2_val}; wr_en = 1'b1; flag_en = 1'b1; end
      4'h2: begin result = s1_val - s2_val; carry = (s1_val >= s2_val); wr_en = 1'b1; flag_en = 1'b1; end
      4'h3: begin result = s1_val & s2_val; wr_en = 1'b1; flag_en = 1'b1; end
      4'h4: begin result = s1_val | s2_val; wr_en = 1'b1; flag_en = 1'b1; end
      4'h5: begin result = s1_val ^ s2_val; wr_en = 1'b1; flag_en = 1'b1; end
      4'h6: begin {carry, result} = {1'b0, s1_val} << s2_val[4:0]; wr_en = 1'b1; flag_en = 1'b1; end
      4'h7: begin {result, carry} = {s1_val, 1'b0} >> s2_val[4:0]; wr_en = 1'b1; flag_en = 1'b1; end
      4'h8: begin result = WIDTH'(s1_val < s2_val); wr_en = 1'b1; flag_en = 1'b1; end
      4'h9: begin result = s1_val; wr_en = 1'b1; end
      4'hA: jump = (s2_val == '0);
      4'hB: jump = (s2_val != '0);
      4'hC: begin jump = 1'b1; is_call = 1'b1; end
      4'hE: begin result = WIDTH'(ir_q[7:0]); wr_en = 1'b1; end
      4'hF: begin result = {d_val[WIDTH-9:0], ir_q[7:0]}; wr_en = 1'b1; end
      default: ;
    endcase
    // a register write aimed at r15 is a jump to the written value
    if (wr_en && d_idx == 4'd15) begin
      jump   = 1'b1;
      target = result[AW-1:0];
    end
  end

  // next-state, pc, IR, flag and register-file updates
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    regs_d  = regs_q;
    case (state_q)
      S_FETCH: if (run_q && bus.ins_valid) begin
        ir_d    = bus.ins;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = jump ? target : pc_inc;
        state_d = (op == 4'hD) ? S_HALT : S_FETCH;
        if (flag_en) flags_d = {result[WIDTH-1], carry, (result == '0)};
        for (int i = 1; i <= 14; i++) begin
          if (wr_en && d_idx == 4'(i)) regs_d[i] = result;
        end
        if (is_call) regs_d[4] = WIDTH'(pc_inc);
      end
      S_HALT: if (bus.sys_ack) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
    // the external loader overrides any same-cycle write to r3
    if (bus.load_signal) regs_d[3] = bus.load_data;
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      for (int i = 1; i <= 14; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      for (int i = 1; i <= 14; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule
